// File: rtl/mcs4_pc_stack_if.sv
// Decoder-side bundle for the MCS-4 program counter / return-address stack.
// Latency: n/a (wiring only); ops and status cross it unregistered.
// Backpressure: none; the stack accepts one op every cycle.
interface mcs4_pc_stack_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 3
);
    localparam int DW = $clog2(DEPTH + 1);

    logic                  op_valid;
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] target_addr;
    logic                  err_clr;

    logic [ADDR_WIDTH-1:0] pc;
    logic [DW-1:0]         depth;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output op_valid, op, target_addr, err_clr,
        input  pc, depth, full, empty, overflow, underflow
    );

    modport slave (
        input  op_valid, op, target_addr, err_clr,
        output pc, depth, full, empty, overflow, underflow
    );
endinterface

// File: rtl/mcs4_pc_stack.sv
// MCS-4 program counter with a DEPTH-level return-address stack (wrap or saturate).
// Latency: one cycle; an op sampled on edge N is visible on pc/depth/flags after edge N.
// Backpressure: none; every valid op is consumed, illegal push/pop only raise sticky flags.
module mcs4_pc_stack #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 3,
    parameter int WRAP_MODE  = 1,
    parameter int RESET_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mcs4_pc_stack_if.slave   bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_HOLD      = 3'd0;
    localparam logic [2:0] OP_INC       = 3'd1;
    localparam logic [2:0] OP_JUMP      = 3'd2;
    localparam logic [2:0] OP_CALL      = 3'd3;
    localparam logic [2:0] OP_RET       = 3'd4;
    localparam logic [2:0] OP_PAGE_JUMP = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(32'hFF);
    localparam logic [PW-1:0]         WP_LAST   = PW'(DEPTH - 1);
    localparam logic [DW-1:0]         DEPTH_MAX = DW'(DEPTH);
    localparam bit                    WRAP      = (WRAP_MODE != 0);

    if (DEPTH < 1) begin : g_bad_depth
        $error("mcs4_pc_stack: DEPTH must be at least 1");
    end

    logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;
    logic [ADDR_WIDTH-1:0] stack_q [DEPTH];
    logic [PW-1:0]         wp_q, wp_nxt, wp_inc, wp_dec;
    logic [DW-1:0]         depth_q, depth_nxt;
    logic                  ovf_q, unf_q;
    logic                  push, ovf_set, unf_set;
    logic                  is_full, is_empty;

    assign is_full  = (depth_q == DEPTH_MAX);
    assign is_empty = (depth_q == '0);
    assign wp_inc   = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
    assign wp_dec   = (wp_q == '0) ? WP_LAST : wp_q - 1'b1;

    always_comb begin
        pc_nxt    = pc_q;
        wp_nxt    = wp_q;
        depth_nxt = depth_q;
        push      = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (bus.op_valid) begin
            case (bus.op)
                OP_INC:       pc_nxt = pc_q + 1'b1;
                OP_JUMP:      pc_nxt = bus.target_addr;
                OP_PAGE_JUMP: pc_nxt = (pc_q & ~PAGE_MASK) | (bus.target_addr & PAGE_MASK);
                OP_CALL: begin
                    if (is_full) begin
                        ovf_set = 1'b1;
                    end
                    // A full saturating stack drops the whole CALL, jump included.
                    if (!is_full || WRAP) begin
                        push   = 1'b1;
                        wp_nxt = wp_inc;
                        pc_nxt = bus.target_addr;
                        if (!is_full) begin
                            depth_nxt = depth_q + 1'b1;
                        end
                    end
                end
                OP_RET: begin
                    if (is_empty) begin
                        unf_set = 1'b1;
                    end
                    // Wrap mode pops even when empty and returns whatever the slot holds.
                    if (!is_empty || WRAP) begin
                        wp_nxt = wp_dec;
                        pc_nxt = stack_q[wp_dec];
                        if (!is_empty) begin
                            depth_nxt = depth_q - 1'b1;
                        end
                    end
                end
                OP_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ADDR_WIDTH'(RESET_ADDR);
            wp_q    <= '0;
            depth_q <= '0;
        end else begin
            pc_q    <= pc_nxt;
            wp_q    <= wp_nxt;
            depth_q <= depth_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            stack_q[wp_q] <= pc_q;
        end
    end

    // Sticky flags: a same-cycle set beats err_clr; err_clr ignores op_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (bus.err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.depth     = depth_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_mcs4_pc_stack.sv
// Bench for mcs4_pc_stack: wrap and saturating instances driven in lockstep,
// compared against an array/queue reference model after every op.
module tb_mcs4_pc_stack;
    localparam int AW = 12;
    localparam int D  = 3;
    localparam int DW = $clog2(D + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcs4_pc_stack_if #(.ADDR_WIDTH(AW), .DEPTH(D)) bw ();
    mcs4_pc_stack_if #(.ADDR_WIDTH(AW), .DEPTH(D)) bs ();

    mcs4_pc_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(1), .RESET_ADDR(0)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw.slave)
    );

    mcs4_pc_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(0), .RESET_ADDR(0)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    // Wrap model: absolute push count, slot = count mod D, so stale data survives.
    logic [AW-1:0] w_pc;
    logic [AW-1:0] w_mem [D];
    int            w_wp;
    int            w_depth;
    bit            w_ovf, w_unf;
    // Saturating model: a bounded queue.
    logic [AW-1:0] s_pc;
    logic [AW-1:0] s_q [$];
    bit            s_ovf, s_unf;

    int checks = 0;
    int errors = 0;

    function automatic int slot(input int p);
        return ((p % D) + D) % D;
    endfunction

    task automatic model_reset();
        w_pc = '0; w_wp = 0; w_depth = 0; w_ovf = 0; w_unf = 0;
        for (int i = 0; i < D; i++) w_mem[i] = '0;
        s_pc = '0; s_q.delete(); s_ovf = 0; s_unf = 0;
    endtask

    task automatic model_op(input bit v, input logic [2:0] op, input logic [AW-1:0] t, input bit clr);
        if (clr) begin
            w_ovf = 0; w_unf = 0; s_ovf = 0; s_unf = 0;
        end
        if (v) begin
            case (op)
                3'd1: begin
                    w_pc = AW'(w_pc + 1);
                    s_pc = AW'(s_pc + 1);
                end
                3'd2: begin
                    w_pc = t;
                    s_pc = t;
                end
                3'd3: begin
                    w_mem[slot(w_wp)] = w_pc;
                    w_wp++;
                    w_pc = t;
                    if (w_depth < D) w_depth++; else w_ovf = 1;
                    if (s_q.size() < D) begin
                        s_q.push_back(s_pc);
                        s_pc = t;
                    end else begin
                        s_ovf = 1;
                    end
                end
                3'd4: begin
                    w_wp--;
                    w_pc = w_mem[slot(w_wp)];
                    if (w_depth > 0) w_depth--; else w_unf = 1;
                    if (s_q.size() > 0) s_pc = s_q.pop_back(); else s_unf = 1;
                end
                3'd5: begin
                    w_pc = {w_pc[AW-1:8], t[7:0]};
                    s_pc = {s_pc[AW-1:8], t[7:0]};
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".w.pc"},    32'(bw.pc),        32'(w_pc));
        chk({tag, ".w.depth"}, 32'(bw.depth),     32'(w_depth));
        chk({tag, ".w.full"},  32'(bw.full),      32'(w_depth == D));
        chk({tag, ".w.empty"}, 32'(bw.empty),     32'(w_depth == 0));
        chk({tag, ".w.ovf"},   32'(bw.overflow),  32'(w_ovf));
        chk({tag, ".w.unf"},   32'(bw.underflow), 32'(w_unf));
        chk({tag, ".s.pc"},    32'(bs.pc),        32'(s_pc));
        chk({tag, ".s.depth"}, 32'(bs.depth),     32'(s_q.size()));
        chk({tag, ".s.full"},  32'(bs.full),      32'(s_q.size() == D));
        chk({tag, ".s.empty"}, 32'(bs.empty),     32'(s_q.size() == 0));
        chk({tag, ".s.ovf"},   32'(bs.overflow),  32'(s_ovf));
        chk({tag, ".s.unf"},   32'(bs.underflow), 32'(s_unf));
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [AW-1:0] t, input bit clr);
        bw.op_valid = v;  bs.op_valid = v;
        bw.op = op;       bs.op = op;
        bw.target_addr = t; bs.target_addr = t;
        bw.err_clr = clr; bs.err_clr = clr;
    endtask

    task automatic step(input bit v, input logic [2:0] op, input logic [AW-1:0] t, input bit clr, input string tag);
        drive(v, op, t, clr);
        @(posedge clk);
        #1;
        model_op(v, op, t, clr);
        check_all(tag);
        drive(1'b0, 3'd0, '0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 3'd0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Increment and wrap at the top of the address space
        step(1, 3'd1, '0, 0, "inc1");
        step(1, 3'd1, '0, 0, "inc2");
        step(1, 3'd1, '0, 0, "inc3");
        chk("plan.inc3", 32'(bw.pc), 32'h003);
        step(1, 3'd2, 12'hFFF, 0, "jmp_fff");
        step(1, 3'd1, '0, 0, "inc_wrap");
        chk("plan.inc_wrap", 32'(bw.pc), 32'h000);

        // Three nested calls and returns
        step(1, 3'd2, 12'h010, 0, "jmp_010");
        step(1, 3'd3, 12'h100, 0, "call1");
        step(1, 3'd3, 12'h200, 0, "call2");
        step(1, 3'd3, 12'h300, 0, "call3");
        chk("plan.full", 32'(bw.full), 32'h1);
        step(1, 3'd4, '0, 0, "ret1");
        chk("plan.ret1", 32'(bw.pc), 32'h200);
        step(1, 3'd4, '0, 0, "ret2");
        step(1, 3'd4, '0, 0, "ret3");
        chk("plan.ret3", 32'(bw.pc), 32'h010);

        // Overflow: wrap overwrites oldest, saturating suppresses; set beats err_clr
        step(1, 3'd2, 12'h010, 0, "jmp_010b");
        step(1, 3'd3, 12'h100, 0, "ocall1");
        step(1, 3'd3, 12'h200, 0, "ocall2");
        step(1, 3'd3, 12'h300, 0, "ocall3");
        step(1, 3'd3, 12'h400, 1, "ocall4_clr");
        chk("plan.sat_pc", 32'(bs.pc), 32'h300);
        chk("plan.wrap_ovf", 32'(bw.overflow), 32'h1);
        step(1, 3'd4, '0, 0, "oret1");
        chk("plan.wrap_ret1", 32'(bw.pc), 32'h300);
        step(1, 3'd4, '0, 0, "oret2");
        step(1, 3'd4, '0, 0, "oret3");
        chk("plan.wrap_ret3", 32'(bw.pc), 32'h100);
        chk("plan.sat_ret3", 32'(bs.pc), 32'h010);
        step(1, 3'd4, '0, 0, "ret_empty");
        chk("plan.sat_unf_hold", 32'(bs.pc), 32'h010);
        step(0, 3'd0, '0, 1, "err_clr");
        chk("plan.clr_ovf", 32'(bs.overflow), 32'h0);

        // Page jump and the various no-op forms
        step(1, 3'd2, 12'h3A5, 0, "jmp_3a5");
        step(1, 3'd5, 12'h0C2, 0, "page");
        chk("plan.page", 32'(bw.pc), 32'h3C2);
        step(1, 3'd0, 12'hABC, 0, "hold");
        step(0, 3'd2, 12'hABC, 0, "invalid");
        step(1, 3'd6, 12'hABC, 0, "op6");
        step(1, 3'd7, 12'hABC, 0, "op7");

        // Randomised ops with occasional err_clr
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 85, 3'($urandom_range(0, 7)), AW'($urandom),
                 $urandom_range(0, 9) == 0, "rnd");
        end

        // Asynchronous reset mid-sequence: depth 2, pc 0x123, overflow set
        step(1, 3'd0, '0, 1, "pre_clr");
        step(1, 3'd4, '0, 0, "pre_r1");
        step(1, 3'd4, '0, 0, "pre_r2");
        step(1, 3'd4, '0, 0, "pre_r3");
        step(1, 3'd3, 12'h100, 0, "pre_c1");
        step(1, 3'd3, 12'h200, 0, "pre_c2");
        step(1, 3'd3, 12'h300, 0, "pre_c3");
        step(1, 3'd3, 12'h400, 0, "pre_c4");
        step(1, 3'd4, '0, 0, "pre_r4");
        step(1, 3'd2, 12'h123, 0, "pre_j");
        chk("plan.pre_depth", 32'(bw.depth), 32'h2);
        chk("plan.pre_ovf", 32'(bw.overflow), 32'h1);
        #2;
        drive(1'b1, 3'd3, 12'h555, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("plan.arst_pc", 32'(bw.pc), 32'h000);
        @(posedge clk);
        #1;
        check_all("arst_hold");
        drive(1'b0, 3'd0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3'd4, '0, 0, "ret_after_rst");
        step(1, 3'd3, 12'h0AB, 0, "call_after_rst");
        step(1, 3'd4, '0, 0, "ret_after_call");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcs4_pc_stack.md
# mcs4_pc_stack

Parametrised program-counter and subroutine return-address stack for the MCS-4 CPU core. It generalises the fixed 12-bit, 3-level 4004 address stack to configurable address width and depth. It offers two overflow modes: circular wrap, which is 4004-faithful, and saturating with trap flags. The block sits between the instruction decoder (JUN/JMS/BBL/JCN/ISZ/JIN/FIN) and the ROM address driver, and supplies the fetch address each instruction cycle.

## Interface
Parameters:
- ADDR_WIDTH, 12: width of PC and of each stack entry.
- DEPTH, 3: number of return-address levels, excluding the PC; must be ≥1.
- WRAP_MODE, 1:
  - 1 = circular stack; overflow overwrites the oldest entry.
  - 0 = saturating; an illegal push or pop is suppressed.
- RESET_ADDR, 0: PC value after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  qualifies op; when low, state holds.
- op  in  3  operation code:
  - 0 HOLD
  - 1 INC
  - 2 JUMP
  - 3 CALL
  - 4 RET
  - 5 PAGE_JUMP
  - 6–7 treated as HOLD
- target_addr  in  ADDR_WIDTH  destination for JUMP, CALL and PAGE_JUMP.
- err_clr  in  1  clears the sticky overflow and underflow flags.
- pc  out  ADDR_WIDTH  registered current fetch address.
- depth  out  $clog2(DEPTH+1)  number of valid stack entries, 0..DEPTH.
- full  out  1  high when depth == DEPTH.
- empty  out  1  high when depth == 0.
- overflow  out  1  sticky; set by a CALL issued while full.
- underflow  out  1  sticky; set by a RET issued while empty.

## Operation
State:
- pc register.
- DEPTH-entry storage array.
- Write pointer wp, range 0..DEPTH-1, pointing at the next free slot.
- depth counter.

Operations (each applies only when op_valid = 1):
- INC: pc ← pc+1 modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
- JUMP: pc ← target_addr.
- PAGE_JUMP: pc[7:0] ← target_addr[7:0]; pc[ADDR_WIDTH-1:8] is unchanged.
  - Any 4004 last-byte-of-page correction is the decoder's job: it must issue a JUMP instead.
- CALL, normal case:
  - stack[wp] ← pc (the decoder has already advanced pc past the JMS second byte).
  - wp ← (wp+1) mod DEPTH.
  - depth ← depth+1.
  - pc ← target_addr.
- RET, normal case:
  - wp ← (wp−1) mod DEPTH.
  - pc ← stack[(wp−1) mod DEPTH].
  - depth ← depth−1.

CALL while full:
- WRAP_MODE=1: perform the push and jump, overwriting the oldest entry; depth stays DEPTH; overflow ← 1.
- WRAP_MODE=0: no write, wp, depth and pc all unchanged; overflow ← 1.

RET while empty:
- WRAP_MODE=1: perform the pop (stale or overwritten entry returned, wp decrements); depth stays 0; underflow ← 1.
- WRAP_MODE=0: pc, wp and depth all unchanged; underflow ← 1.

Flags and status:
- err_clr in the same cycle as a flag-setting event: the set wins.
- err_clr is honoured regardless of op_valid.
- full and empty are combinational decodes of depth.

## Timing
Reset (asserted asynchronously, deasserted synchronously by the system):
- pc = RESET_ADDR.
- All stack entries = 0; wp = 0; depth = 0.
- full = 0, empty = 1, overflow = 0, underflow = 0.
- Reset mid-operation discards any in-flight op; there is no partial update.

Latency and throughput:
- Single-cycle: the op sampled at edge N is visible on pc, depth and the flags after edge N.
- One op per cycle; there is no back-pressure.
- Back-to-back CALL/RET is legal; RET in the cycle after CALL returns the just-pushed address.
- The stack read for RET is combinational from the array; pc is the only registered address path.
- The CPU issues at most one op per 8-cycle instruction. The block itself places no constraint on issue rate.

## Test plan
- Reset, then 3× INC from RESET_ADDR=0 → pc=0x003. Then JUMP 0xFFF, INC → pc=0x000, no flags.
- DEPTH=3, pc=0x010: CALL 0x100, CALL 0x200, CALL 0x300 → depth=3, full=1. Then 3× RET → pc sequence 0x200, 0x100, 0x010; empty=1; no flags.
- WRAP_MODE=1, 4 CALLs from pc=0x010 to 0x100, 0x200, 0x300, 0x400 → overflow=1, depth=3. Then 3× RET → 0x300, 0x200, 0x100 (0x010 lost).
- WRAP_MODE=0, same 4 CALLs → 4th suppressed: pc=0x300, overflow=1. A RET on empty holds pc and sets underflow; err_clr clears both next cycle.
- pc=0x3A5, PAGE_JUMP 0x0C2 → pc=0x3C2. A HOLD or op_valid=0 cycle leaves all outputs unchanged.
- Assert rst_n low mid-sequence (depth=2, pc=0x123, overflow=1) → immediate pc=0, depth=0, empty=1, flags=0 before the next clock edge.
